video_pos_tracker: RTL

//  Video-domain stage directly upstream of the OSD overlay. Takes raw vs/hs/de/rgb timing and

---
 rtl/video_pkg.sv | 9 +
 rtl/vid_edge_det.sv | 16 +
 rtl/video_pos_tracker.sv | 125 ++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared widths, tracker states and the sync edge-detect helper.
package video_pkg;
   localparam int POS_W   = 11;
   localparam int POS_MAX = 2047;
   typedef enum logic {WAIT_VS, RUN} state_t;
   function automatic logic edge_of(input logic cur, input logic prev, input logic rising);
      return rising ? (cur & ~prev) : (~cur & prev);
   endfunction
endpackage

// File: rtl/vid_edge_det.sv
// vid_edge_det: registers a sync and flags its selected edge against the registered copy.
module vid_edge_det
   import video_pkg::*;
#(
   parameter bit RISING = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic ed
);
   always_ff @(posedge clk)
      q <= rst ? 1'b0 : d;
   assign ed = edge_of(d, q, RISING);
endmodule

// File: rtl/video_pos_tracker.sv
// video_pos_tracker: 1-cycle stream delay with pixel coordinates, frame-size measurement and lock.
// Define VIDEO_POS_TRACKER_STATS_EN to add the frame_cnt/err_cnt statistics ports.
module video_pos_tracker
   import video_pkg::*;
#(
   parameter int SCREEN_WIDTH     = 1920,
   parameter int SCREEN_HEIGHT    = 1080,
   parameter int PIXEL_DATA_WIDTH = 16,
   parameter bit VS_ACTIVE_HIGH   = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        vs_in,
   input  logic                        hs_in,
   input  logic                        de_in,
   input  logic [PIXEL_DATA_WIDTH-1:0] rgb_in,
   output logic                        vs_out,
   output logic                        hs_out,
   output logic                        de_out,
   output logic [PIXEL_DATA_WIDTH-1:0] rgb_out,
   output logic [POS_W-1:0]            pos_x,
   output logic [POS_W-1:0]            pos_y,
   output logic                        locked,
   output logic [POS_W-1:0]            meas_width,
   output logic [POS_W-1:0]            meas_height,
   output logic                        meas_valid,
   output logic                        fmt_err
`ifdef VIDEO_POS_TRACKER_STATS_EN
   ,
   output logic [15:0]                 frame_cnt,
   output logic [15:0]                 err_cnt
`endif
);
   state_t state, state_n;
   logic fs, de_fall, run, x_sat, y_sat, len_bad, frame_err, line_err;
   logic [POS_W-1:0] x, y, ref_len, x_inc;

   vid_edge_det #(.RISING(VS_ACTIVE_HIGH)) u_vs (.clk(clk), .rst(rst), .d(vs_in), .q(vs_out), .ed(fs));
   vid_edge_det #(.RISING(1'b0))           u_de (.clk(clk), .rst(rst), .d(de_in), .q(de_out), .ed(de_fall));

   always_ff @(posedge clk)
      state <= rst ? WAIT_VS : state_n;

   always_comb begin
      state_n = state;
      if (fs) state_n = RUN;
   end

   assign run       = (state == RUN);
   assign x_sat     = (x == POS_W'(POS_MAX));
   assign y_sat     = (y == POS_W'(POS_MAX));
   assign x_inc     = x_sat ? x : x + 1'b1;
   assign len_bad   = (y != '0) && (x != ref_len);
   assign frame_err = (ref_len != POS_W'(SCREEN_WIDTH)) | (y != POS_W'(SCREEN_HEIGHT)) | line_err;

   // fs outranks a coincident pixel or line end: that pixel becomes (0,0) of the new frame
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_out      <= 1'b0;
         rgb_out     <= '0;
         pos_x       <= '0;
         pos_y       <= '0;
         locked      <= 1'b0;
         meas_width  <= '0;
         meas_height <= '0;
         meas_valid  <= 1'b0;
         fmt_err     <= 1'b0;
         x           <= '0;
         y           <= '0;
         ref_len     <= '0;
         line_err    <= 1'b0;
      end else begin
         hs_out     <= hs_in;
         rgb_out    <= rgb_in;
         meas_valid <= 1'b0;
         pos_x      <= '0;
         pos_y      <= '0;
         if (fs) begin
            x        <= POS_W'(de_in);
            y        <= '0;
            ref_len  <= '0;
            line_err <= 1'b0;
            if (run) begin
               fmt_err <= frame_err;
               locked  <= ~frame_err & (y != '0);
               if (y != '0) begin
                  meas_width  <= ref_len;
                  meas_height <= y;
                  meas_valid  <= 1'b1;
               end
            end
         end else if (run) begin
            if (de_in) begin
               pos_x <= x;
               pos_y <= y;
               x     <= x_inc;
               if (x_sat) begin
                  line_err <= 1'b1;
                  fmt_err  <= 1'b1;
               end
            end else if (de_fall) begin
               x <= '0;
               y <= y_sat ? y : y + 1'b1;
               if (y == '0) ref_len <= x;
               if (len_bad || y_sat) begin
                  line_err <= 1'b1;
                  fmt_err  <= 1'b1;
               end
            end
         end
      end
   end

`ifdef VIDEO_POS_TRACKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else if (fs && run) begin
         frame_cnt <= frame_cnt + 1'b1;
         if (frame_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      end
   end
`endif
endmodule
